// File: rtl/accel_pkg.sv
// accel_pkg: shared feeder state type, default geometry and flush-length helper
package accel_pkg;
    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_ARRAY_SIZE = 16;
    typedef enum logic [1:0] {IDLE, STREAM, FLUSH} feeder_state_t;
    function automatic int flush_len(input int n);
        return 2 * n - 1;
    endfunction
endpackage

// File: rtl/vec_fifo.sv
// vec_fifo: synchronous vector FIFO, registered read pointer, no write-to-read bypass
module vec_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, rd_q;
    logic [CW-1:0]    cnt_q;
    // storage write; contents need no reset since occupancy gates every read
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_q] <= wdata_i;
    end
    // pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_i) wr_q <= wr_q + 1'b1;
            if (pop_i) rd_q <= rd_q + 1'b1;
            cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
        end
    end
    assign rdata_o = mem_q[rd_q];
    assign empty_o = cnt_q == '0;
    assign count_o = cnt_q;
endmodule

// File: rtl/activation_skew_feeder.sv
// activation_skew_feeder: buffers activation vectors and feeds them row-skewed into the systolic array
module activation_skew_feeder
    import accel_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ARRAY_SIZE = DEFAULT_ARRAY_SIZE,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [ARRAY_SIZE*DATA_WIDTH-1:0] in_data,
    input  logic                             in_last,
    output logic [ARRAY_SIZE*DATA_WIDTH-1:0] act_out,
    output logic                             array_enable,
    output logic                             busy,
    output logic                             tile_done
);
    localparam int VW = ARRAY_SIZE * DATA_WIDTH;
    localparam int CW = $clog2(2 * ARRAY_SIZE);
    localparam int FCW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] FLUSH_LAST = CW'(flush_len(ARRAY_SIZE) - 1);
    feeder_state_t  state_q;
    logic [CW-1:0]  flush_cnt_q;
    logic           enable_q, done_q;
    logic [VW:0]    fifo_rdata;
    logic [VW-1:0]  fifo_vec, step_vec;
    logic           fifo_last, fifo_empty, push, pop, step;
    logic [FCW-1:0] fifo_count;
    assign in_ready  = !rst && fifo_count != FCW'(FIFO_DEPTH);
    assign push      = in_valid && in_ready;
    assign fifo_vec  = fifo_rdata[VW-1:0];
    assign fifo_last = fifo_rdata[VW];
    assign pop       = state_q == STREAM && !fifo_empty;
    assign step      = pop || state_q == FLUSH;
    assign step_vec  = pop ? fifo_vec : '0;
    vec_fifo #(.WIDTH(VW + 1), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .wdata_i ({in_last, in_data}),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );
    // control FSM: pops one vector per cycle in STREAM, injects zero steps in FLUSH, pulses done at the end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            flush_cnt_q <= '0;
            enable_q    <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            enable_q <= step;
            done_q   <= 1'b0;
            case (state_q)
                IDLE:   if (!fifo_empty) state_q <= STREAM;
                STREAM: if (pop && fifo_last) begin
                    state_q     <= FLUSH;
                    flush_cnt_q <= '0;
                end
                FLUSH:  if (flush_cnt_q == FLUSH_LAST) begin
                    state_q <= IDLE;
                    done_q  <= 1'b1;
                end else begin
                    flush_cnt_q <= flush_cnt_q + 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    for (genvar g = 0; g < ARRAY_SIZE; g++) begin : g_lane
        logic [DATA_WIDTH-1:0] dl_q [g+1];
        // lane g delay line of g+1 stages; advances only on step cycles so stalls freeze the skew
        always_ff @(posedge clk) begin
            if (rst) begin
                for (int j = 0; j <= g; j++) dl_q[j] <= '0;
            end else if (step) begin
                dl_q[0] <= step_vec[g*DATA_WIDTH +: DATA_WIDTH];
                for (int j = 1; j <= g; j++) dl_q[j] <= dl_q[j-1];
            end
        end
        assign act_out[g*DATA_WIDTH +: DATA_WIDTH] = dl_q[g];
    end
    assign array_enable = enable_q;
    assign tile_done    = done_q;
    assign busy         = state_q != IDLE;
endmodule
